// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two small result FIFOs (ALU, LSB) drained round-robin onto a
// single registered broadcast port, with backpressure, global stall and rollback flush.
module cdb_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ROB_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       rollback,

    input  logic                       alu_valid,
    input  logic [DATA_W-1:0]          alu_val,
    input  logic [ROB_W-1:0]           alu_rob_entry,
    output logic                       alu_ready,

    input  logic                       lsb_valid,
    input  logic [DATA_W-1:0]          lsb_val,
    input  logic [ROB_W-1:0]           lsb_rob_entry,
    output logic                       lsb_ready,

    output logic                       cdb_valid,
    output logic [DATA_W-1:0]          cdb_val,
    output logic [ROB_W-1:0]           cdb_rob_entry,
    output logic                       cdb_src,

    output logic [$clog2(DEPTH):0]     alu_count,
    output logic [$clog2(DEPTH):0]     lsb_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = DATA_W + ROB_W;

    logic [EW-1:0] alu_mem [DEPTH];
    logic [EW-1:0] lsb_mem [DEPTH];

    logic [PW-1:0] alu_head, alu_tail;
    logic [PW-1:0] lsb_head, lsb_tail;

    // 1 means the LSB won last, so the ALU is preferred next.
    logic          last_grant;

    logic          alu_accept, lsb_accept;
    logic          grant_alu, grant_lsb;
    logic [EW-1:0] alu_head_entry, lsb_head_entry;

    assign alu_ready = rdy && !rollback && (alu_count < CW'(DEPTH));
    assign lsb_ready = rdy && !rollback && (lsb_count < CW'(DEPTH));

    assign alu_accept = alu_valid && alu_ready;
    assign lsb_accept = lsb_valid && lsb_ready;

    assign alu_head_entry = alu_mem[alu_head];
    assign lsb_head_entry = lsb_mem[lsb_head];

    always_comb begin
        grant_alu = 1'b0;
        grant_lsb = 1'b0;
        if (rdy && !rollback) begin
            if ((alu_count != '0) && (lsb_count != '0)) begin
                if (last_grant) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_lsb = 1'b1;
                end
            end else if (alu_count != '0) begin
                grant_alu = 1'b1;
            end else if (lsb_count != '0) begin
                grant_lsb = 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (!rst && alu_accept) begin
            alu_mem[alu_tail] <= {alu_val, alu_rob_entry};
        end
        if (!rst && lsb_accept) begin
            lsb_mem[lsb_tail] <= {lsb_val, lsb_rob_entry};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_head      <= '0;
            alu_tail      <= '0;
            alu_count     <= '0;
            lsb_head      <= '0;
            lsb_tail      <= '0;
            lsb_count     <= '0;
            last_grant    <= 1'b1;
            cdb_valid     <= 1'b0;
            cdb_val       <= '0;
            cdb_rob_entry <= '0;
            cdb_src       <= 1'b0;
        end else if (rollback) begin
            alu_head   <= '0;
            alu_tail   <= '0;
            alu_count  <= '0;
            lsb_head   <= '0;
            lsb_tail   <= '0;
            lsb_count  <= '0;
            last_grant <= 1'b1;
            cdb_valid  <= 1'b0;
        end else if (rdy) begin
            if (alu_accept) begin
                alu_tail <= alu_tail + PW'(1);
            end
            if (lsb_accept) begin
                lsb_tail <= lsb_tail + PW'(1);
            end
            alu_count <= alu_count + CW'(alu_accept) - CW'(grant_alu);
            lsb_count <= lsb_count + CW'(lsb_accept) - CW'(grant_lsb);

            cdb_valid <= grant_alu || grant_lsb;
            if (grant_alu) begin
                alu_head      <= alu_head + PW'(1);
                cdb_val       <= alu_head_entry[EW-1:ROB_W];
                cdb_rob_entry <= alu_head_entry[ROB_W-1:0];
                cdb_src       <= 1'b0;
                last_grant    <= 1'b0;
            end else if (grant_lsb) begin
                lsb_head      <= lsb_head + PW'(1);
                cdb_val       <= lsb_head_entry[EW-1:ROB_W];
                cdb_rob_entry <= lsb_head_entry[ROB_W-1:0];
                cdb_src       <= 1'b1;
                last_grant    <= 1'b1;
            end
        end
    end

endmodule
